// File: rtl/xc_funnel_shift_unit_if.sv
// Operand/result handshake bundle for the multi-cycle funnel shifter.
// master drives operands and accepts results; slave is the shifter.
interface xc_funnel_shift_unit_if #(parameter int XLEN = 32);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic            op_fsl;
   logic            op_fsr;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic [XLEN-1:0] rs3;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;

   modport master (
      output flush, in_valid, op_fsl, op_fsr, rs1, rs2, rs3, out_ready,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  flush, in_valid, op_fsl, op_fsr, rs1, rs2, rs3, out_ready,
      output in_ready, out_valid, result
   );
endinterface

// File: rtl/xc_funnel_shift_unit.sv
// Multi-cycle funnel shifter (FSL/FSR/FSRI): rotates {rs1,rs3} right in log2
// steps, STEPS_PER_CYCLE steps per clock, and returns the upper half as rd.
module xc_funnel_shift_unit #(
   parameter int XLEN            = 32,
   parameter int STEPS_PER_CYCLE = 1
) (
   input  logic                  g_clk,
   input  logic                  g_reset,
   xc_funnel_shift_unit_if.slave bus
);
   localparam int         N    = 6 / STEPS_PER_CYCLE;
   localparam logic [2:0] S3   = 3'(STEPS_PER_CYCLE);
   localparam int         AW   = 2 * XLEN;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state;
   logic [AW-1:0]   a;
   logic [AW-1:0]   a_next;
   logic [5:0]      amt;
   logic [5:0]      amt_in;
   logic [2:0]      step;
   logic [2:0]      cnt;
   logic            unused_rs2;

   assign unused_rs2 = ^bus.rs2[XLEN-1:6];

   // FSL becomes a right rotate by the 6-bit two's complement of the shift;
   // any op other than a clean FSL is executed as FSR.
   assign amt_in = (bus.op_fsl && !bus.op_fsr) ? 6'd0 - bus.rs2[5:0] : bus.rs2[5:0];

   always_comb begin
      a_next = a;
      for (int k = 5; k >= 0; k--) begin
         if (k <= int'(step) && k > int'(step) - STEPS_PER_CYCLE && amt[k])
            a_next = (a_next >> (1 << k)) | (a_next << (AW - (1 << k)));
      end
   end

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         state         <= IDLE;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.result    <= '0;
         a             <= '0;
         amt           <= '0;
         step          <= '0;
         cnt           <= '0;
      end else if (bus.flush) begin
         state         <= IDLE;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               a            <= {bus.rs1, bus.rs3};
               amt          <= amt_in;
               step         <= 3'd5;
               cnt          <= 3'(N);
               bus.in_ready <= 1'b0;
               state        <= BUSY;
            end
            BUSY: if (cnt != 3'd0) begin
               a    <= a_next;
               step <= step - S3;
               cnt  <= cnt - 3'd1;
            end else begin
               // one extra cycle registers the result so out_valid and data rise together
               bus.result    <= a[AW-1:XLEN];
               bus.out_valid <= 1'b1;
               state         <= DONE;
            end
            DONE: if (bus.out_ready) begin
               bus.out_valid <= 1'b0;
               bus.in_ready  <= 1'b1;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_xc_funnel_shift_unit.sv
// Scoreboard bench: four shifters (1,2,3,6 steps/cycle) share operand and
// control wires; each has its own in_valid/out_ready so one lane runs at a time.
module tb_xc_funnel_shift_unit;
   logic        g_clk = 1'b0;
   logic        g_reset;
   logic        flush;
   logic        op_fsl, op_fsr;
   logic [31:0] rs1, rs2, rs3;
   logic [3:0]  in_valid, out_ready;
   logic [3:0]  in_ready_a, out_valid_a;
   logic [31:0] result_a [4];

   logic [31:0] sb [$];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 g_clk = ~g_clk;

   for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      localparam int SPC = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 3 : 6;
      xc_funnel_shift_unit_if #(.XLEN(32)) bus ();
      assign bus.flush     = flush;
      assign bus.in_valid  = in_valid[gi];
      assign bus.op_fsl    = op_fsl;
      assign bus.op_fsr    = op_fsr;
      assign bus.rs1       = rs1;
      assign bus.rs2       = rs2;
      assign bus.rs3       = rs3;
      assign bus.out_ready = out_ready[gi];
      assign in_ready_a[gi]  = bus.in_ready;
      assign out_valid_a[gi] = bus.out_valid;
      assign result_a[gi]    = bus.result;
      xc_funnel_shift_unit #(.XLEN(32), .STEPS_PER_CYCLE(SPC)) dut (
         .g_clk   (g_clk),
         .g_reset (g_reset),
         .bus     (bus.slave)
      );
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] r1, input logic [31:0] r2,
                                         input logic [31:0] r3, input logic fsl, input logic fsr);
      logic [63:0] x;
      int          s;
      x = {r1, r3};
      s = int'(r2[5:0]);
      if (fsl && !fsr) x = (x << s) | (x >> (64 - s));
      else             x = (x >> s) | (x << (64 - s));
      return x[63:32];
   endfunction

   // Issue one op on a lane, check latency, optionally stall in DONE, then drain.
   task automatic run_op(input int lane, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] r3, input logic fsl, input logic fsr,
                         input int exp_lat, input int hold, input string tag);
      int lat;
      chk({tag, " in_ready before"}, 64'(in_ready_a[lane]), 64'd1);
      rs1 = r1; rs2 = r2; rs3 = r3; op_fsl = fsl; op_fsr = fsr;
      in_valid[lane] = 1'b1;
      @(posedge g_clk);
      sb.push_back(model(r1, r2, r3, fsl, fsr));
      #1;
      in_valid[lane] = 1'b0;
      rs1 = $urandom; rs2 = $urandom; rs3 = $urandom; op_fsl = ~fsl; op_fsr = ~fsr;
      lat = 0;
      while (lat < 20 && !out_valid_a[lane]) begin
         @(posedge g_clk); #1;
         lat++;
      end
      chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
      for (int h = 0; h < hold; h++) begin
         chk({tag, " hold valid"}, 64'(out_valid_a[lane]), 64'd1);
         chk({tag, " hold in_ready"}, 64'(in_ready_a[lane]), 64'd0);
         chk({tag, " hold result"}, 64'(result_a[lane]), 64'(sb[0]));
         @(posedge g_clk); #1;
      end
      out_ready[lane] = 1'b1;
      if (sb.size() == 0) chk({tag, " scoreboard empty"}, 64'd1, 64'd0);
      else chk({tag, " result"}, 64'(result_a[lane]), 64'(sb.pop_front()));
      @(posedge g_clk); #1;
      out_ready[lane] = 1'b0;
      chk({tag, " idle valid"}, 64'(out_valid_a[lane]), 64'd0);
      chk({tag, " idle in_ready"}, 64'(in_ready_a[lane]), 64'd1);
   endtask

   initial begin
      bit seen;
      g_reset = 1'b1; flush = 1'b0; in_valid = '0; out_ready = '0;
      op_fsl = 1'b0; op_fsr = 1'b0; rs1 = '0; rs2 = '0; rs3 = '0;
      repeat (3) @(posedge g_clk);
      #1;
      chk("reset out_valid", 64'(out_valid_a[0]), 64'd0);
      chk("reset in_ready", 64'(in_ready_a[0]), 64'd1);
      chk("reset result", 64'(result_a[0]), 64'd0);
      g_reset = 1'b0;
      @(posedge g_clk); #1;

      run_op(0, 32'h12345678, 32'd8, 32'h9ABCDEF0, 1'b0, 1'b1, 7, 0, "fsr8");
      run_op(0, 32'h12345678, 32'd8, 32'h9ABCDEF0, 1'b1, 1'b0, 7, 0, "fsl8");
      run_op(0, 32'h12345678, 32'd0, 32'h9ABCDEF0, 1'b0, 1'b1, 7, 0, "fsr0");
      run_op(0, 32'h12345678, 32'd32, 32'h9ABCDEF0, 1'b0, 1'b1, 7, 0, "fsr32");
      run_op(0, 32'h12345678, 32'd63, 32'h9ABCDEF0, 1'b1, 1'b0, 7, 0, "fsl63");
      run_op(0, 32'h12345678, 32'hFFFFFFC4, 32'h9ABCDEF0, 1'b0, 1'b1, 7, 0, "fsr_hi");
      run_op(0, 32'h12345678, 32'd0, 32'h9ABCDEF0, 1'b1, 1'b0, 7, 0, "fsl0");
      run_op(0, 32'hDEADBEEF, 32'd12, 32'h01234567, 1'b1, 1'b1, 7, 0, "both");
      run_op(0, 32'hCAFEF00D, 32'd20, 32'h76543210, 1'b0, 1'b0, 7, 0, "neither");
      run_op(0, 32'h12345678, 32'd8, 32'h9ABCDEF0, 1'b0, 1'b1, 7, 5, "stall");
      for (int i = 0; i < 6; i++)
         run_op(0, $urandom, $urandom, $urandom, i[0], ~i[0], 7, 0, "rand");

      // flush during BUSY cycle 3 discards the op
      rs1 = 32'h11111111; rs2 = 32'd4; rs3 = 32'h22222222; op_fsl = 1'b0; op_fsr = 1'b1;
      in_valid[0] = 1'b1;
      @(posedge g_clk); #1;
      in_valid[0] = 1'b0;
      repeat (2) @(posedge g_clk);
      #1 flush = 1'b1;
      @(posedge g_clk); #1;
      flush = 1'b0;
      chk("flush in_ready", 64'(in_ready_a[0]), 64'd1);
      chk("flush out_valid", 64'(out_valid_a[0]), 64'd0);
      seen = 1'b0;
      repeat (10) begin @(posedge g_clk); #1; seen |= out_valid_a[0]; end
      chk("flush no result", 64'(seen), 64'd0);
      run_op(0, 32'h12345678, 32'd8, 32'h9ABCDEF0, 1'b1, 1'b0, 7, 0, "post_flush");

      // flush beats in_valid in IDLE
      flush = 1'b1; in_valid[0] = 1'b1;
      @(posedge g_clk); #1;
      flush = 1'b0; in_valid[0] = 1'b0;
      chk("flush beats accept", 64'(in_ready_a[0]), 64'd1);
      seen = 1'b0;
      repeat (10) begin @(posedge g_clk); #1; seen |= out_valid_a[0]; end
      chk("flush accept no result", 64'(seen), 64'd0);

      // asynchronous reset mid-BUSY
      rs1 = 32'hA5A5A5A5; rs2 = 32'd3; rs3 = 32'h5A5A5A5A; op_fsl = 1'b0; op_fsr = 1'b1;
      in_valid[0] = 1'b1;
      @(posedge g_clk); #1;
      in_valid[0] = 1'b0;
      @(posedge g_clk); #3;
      g_reset = 1'b1;
      #1;
      chk("async rst in_ready", 64'(in_ready_a[0]), 64'd1);
      chk("async rst out_valid", 64'(out_valid_a[0]), 64'd0);
      @(posedge g_clk); #2;
      g_reset = 1'b0;
      @(posedge g_clk); #1;
      seen = 1'b0;
      repeat (10) begin @(posedge g_clk); #1; seen |= out_valid_a[0]; end
      chk("async rst no result", 64'(seen), 64'd0);

      run_op(1, 32'h12345678, 32'd8, 32'h9ABCDEF0, 1'b0, 1'b1, 4, 0, "s2");
      run_op(2, 32'h12345678, 32'd8, 32'h9ABCDEF0, 1'b0, 1'b1, 3, 0, "s3");
      run_op(3, 32'h12345678, 32'd8, 32'h9ABCDEF0, 1'b0, 1'b1, 2, 0, "s6");
      run_op(3, 32'h12345678, 32'd63, 32'h9ABCDEF0, 1'b1, 1'b0, 2, 0, "s6 fsl63");
      run_op(2, 32'h12345678, 32'hFFFFFFC4, 32'h9ABCDEF0, 1'b0, 1'b1, 3, 0, "s3 hi");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
